rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-003 issue_valid  in  1  decode stage presents an instruction this cycle.
REQ-004 issue_wr  in  1  issuing instruction writes issue_dst.
REQ-005 issue_rs, issue_rt, issue_dst  in  4 each  source and destination register IDs.
REQ-006 flush  in  1  discard all pending-write tracking.
REQ-007 alu_wb_valid / alu_wb_ready  in / out  1 / 1  ALU writeback handshake.
REQ-008 alu_wb_reg, alu_wb_data  in  4, 16  ALU writeback target and value.
REQ-009 mem_wb_valid / mem_wb_ready  in / out  1 / 1  load writeback handshake.
REQ-010 mem_wb_reg, mem_wb_data  in  4, 16  load writeback target and value.
REQ-011 dst_reg, dst_data  out  4, 16  register-file write port address and data.
REQ-012 write_reg, write_en  out  1 each  register-file write strobes; always equal.
REQ-013 RF_bypass_en1, RF_bypass_en2  out  1 each  forward dst_data onto rs / rt read data.
REQ-014 stall  out  1  hold decode; issuing instruction not accepted.
REQ-015 busy_map  out  16  scoreboard, bit n = write to register n pending.

Function
REQ-016 Transfer on a source occurs when valid & ready are both high at a rising edge.
REQ-017 At most one ready is high per cycle; ready is high only if that source's valid is high and it wins arbitration.
REQ-018 Both valid: winner = source not granted last (round-robin); grant pointer updates only on a transfer; after reset pointer favours mem.
REQ-019 Transfer in cycle N -> dst_reg/dst_data registered, write_en = write_reg = 1 in cycle N+1 only (latency 1); unheld source data is not required after cycle N.
REQ-020 Transfer with target register 0 completes handshake but gives write_en = 0 in N+1.
REQ-021 RF_bypass_en1 = write_en & (dst_reg == issue_rs) & (issue_rs != 0); RF_bypass_en2 likewise with issue_rt; combinational from registered state.
REQ-022 Operand blocked = busy_map[id] set and not bypassed this cycle; register 0 never blocked.
REQ-023 stall = issue_valid & (rs blocked | rt blocked | (issue_wr & busy_map[issue_dst] & issue_dst != 0)).
REQ-024 Issue accepted = issue_valid & !stall; if issue_wr and issue_dst != 0, set busy_map[issue_dst] at that edge.
REQ-025 write_en high clears busy_map[dst_reg] at that edge; same-edge set and clear of one bit -> set wins.
REQ-026 flush clears every busy_map bit at the edge, overriding set; in-flight write in N+1 still commits; handshakes unaffected.
REQ-027 Writeback to a register whose busy bit is clear commits normally; no error.

Reset
REQ-028 While rst = 0: alu_wb_ready = mem_wb_ready = 0, write_en = write_reg = 0, dst_reg = 0, dst_data = 0, busy_map = 0, grant pointer = mem.
REQ-029 stall and bypass outputs evaluate from reset state (busy_map = 0 -> stall = 0).
REQ-030 Reset mid-transfer drops the pending write; no write_en after release until a new transfer.

Configuration
REQ-031 Macro RF_WB_FIXED_PRIO_EN defined: mem source always wins when both valid; grant pointer removed.
REQ-032 RF_WB_FIXED_PRIO_EN undefined: round-robin per REQ-018.

Verification
REQ-033 Reset release, issue rs=3 rt=4 -> stall 0, busy_map 0x0000, write_en 0.
REQ-034 Issue dst=5 wr=1; next issue rs=5 -> stall 1 until ALU writes r5=0xBEEF; in write cycle stall 0, RF_bypass_en1 1, dst_data 0xBEEF, busy_map[5] cleared next edge.
REQ-035 ALU and mem both valid for 4 cycles, targets r1/r2 -> grants mem, alu, mem, alu; write_en each cycle after first; with RF_WB_FIXED_PRIO_EN grants mem x4.
REQ-036 Same edge: write_en for r7 and accepted issue dst=7 -> busy_map[7] remains 1.
REQ-037 Write to r0 via mem with data 0x1234 -> mem_wb_ready 1, write_en 0 next cycle; issue rs=0 never stalls.
REQ-038 busy_map 0x00F0, flush asserted while r6 writeback in flight -> busy_map 0x0000 next edge, r6 write_en 1 still observed.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks onto one write port and keeps a pending-write scoreboard.
// Optional feature: define RF_WB_FIXED_PRIO_EN to make the load source always win instead of round-robin.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_wr,
  input  logic [3:0]  issue_rs,
  input  logic [3:0]  issue_rt,
  input  logic [3:0]  issue_dst,
  input  logic        flush,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [3:0]  alu_wb_reg,
  input  logic [15:0] alu_wb_data,
  input  logic        mem_wb_valid,
  output logic        mem_wb_ready,
  input  logic [3:0]  mem_wb_reg,
  input  logic [15:0] mem_wb_data,
  output logic [3:0]  dst_reg,
  output logic [15:0] dst_data,
  output logic        write_reg,
  output logic        write_en,
  output logic        RF_bypass_en1,
  output logic        RF_bypass_en2,
  output logic        stall,
  output logic [15:0] busy_map
);

  logic        grant_alu;
  logic        grant_mem;
  logic        xfer;
  logic [3:0]  xfer_reg;
  logic [15:0] xfer_data;

`ifdef RF_WB_FIXED_PRIO_EN
  // Loads always win a collision, so no arbitration history is kept.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst) begin
      if (mem_wb_valid)
        grant_mem = 1'b1;
      else if (alu_wb_valid)
        grant_alu = 1'b1;
    end
  end
`else
  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } prio_e;

  prio_e prio_q;
  prio_e prio_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      prio_q <= PRIO_MEM;
    else
      prio_q <= prio_d;
  end

  // Every grant is a completed transfer, so the loser of this cycle is favoured next.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    prio_d    = prio_q;
    if (rst) begin
      if (mem_wb_valid && alu_wb_valid) begin
        if (prio_q == PRIO_MEM)
          grant_mem = 1'b1;
        else
          grant_alu = 1'b1;
      end else if (mem_wb_valid) begin
        grant_mem = 1'b1;
      end else if (alu_wb_valid) begin
        grant_alu = 1'b1;
      end
    end
    if (grant_mem)
      prio_d = PRIO_ALU;
    else if (grant_alu)
      prio_d = PRIO_MEM;
  end
`endif

  assign alu_wb_ready = grant_alu;
  assign mem_wb_ready = grant_mem;

  always_comb begin
    xfer      = grant_alu || grant_mem;
    xfer_reg  = grant_mem ? mem_wb_reg  : alu_wb_reg;
    xfer_data = grant_mem ? mem_wb_data : alu_wb_data;
  end

  // Writes to r0 complete the handshake but never strobe the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en <= 1'b0;
      dst_reg  <= 4'd0;
      dst_data <= 16'd0;
    end else begin
      write_en <= xfer && (xfer_reg != 4'd0);
      if (xfer) begin
        dst_reg  <= xfer_reg;
        dst_data <= xfer_data;
      end
    end
  end

  assign write_reg = write_en;

  always_comb begin
    RF_bypass_en1 = write_en && (dst_reg == issue_rs) && (issue_rs != 4'd0);
    RF_bypass_en2 = write_en && (dst_reg == issue_rt) && (issue_rt != 4'd0);
  end

  logic        rs_blocked;
  logic        rt_blocked;
  logic        dst_blocked;
  logic        issue_accept;

  always_comb begin
    rs_blocked   = busy_map[issue_rs] && !RF_bypass_en1 && (issue_rs != 4'd0);
    rt_blocked   = busy_map[issue_rt] && !RF_bypass_en2 && (issue_rt != 4'd0);
    dst_blocked  = issue_wr && busy_map[issue_dst] && (issue_dst != 4'd0);
    stall        = issue_valid && (rs_blocked || rt_blocked || dst_blocked);
    issue_accept = issue_valid && !stall;
  end

  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [15:0] busy_d;

  // A new reservation beats a same-edge retire of that register; flush beats both.
  always_comb begin
    set_vec = 16'd0;
    clr_vec = 16'd0;
    if (issue_accept && issue_wr && (issue_dst != 4'd0))
      set_vec[issue_dst] = 1'b1;
    if (write_en)
      clr_vec[dst_reg] = 1'b1;
    if (flush)
      busy_d = 16'd0;
    else
      busy_d = (busy_map & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy_map <= 16'd0;
    else
      busy_map <= busy_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: table of arbitration vectors plus hand-written hazard, flush and reset sequences.
// Expected grants follow RF_WB_FIXED_PRIO_EN when it is defined.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_wr = 1'b0;
  logic [3:0]  issue_rs = 4'd0;
  logic [3:0]  issue_rt = 4'd0;
  logic [3:0]  issue_dst = 4'd0;
  logic        flush = 1'b0;
  logic        alu_wb_valid = 1'b0;
  logic        alu_wb_ready;
  logic [3:0]  alu_wb_reg = 4'd0;
  logic [15:0] alu_wb_data = 16'd0;
  logic        mem_wb_valid = 1'b0;
  logic        mem_wb_ready;
  logic [3:0]  mem_wb_reg = 4'd0;
  logic [15:0] mem_wb_data = 16'd0;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic        write_reg;
  logic        write_en;
  logic        RF_bypass_en1;
  logic        RF_bypass_en2;
  logic        stall;
  logic [15:0] busy_map;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_dst    (issue_dst),
    .flush        (flush),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_reg   (alu_wb_reg),
    .alu_wb_data  (alu_wb_data),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ready (mem_wb_ready),
    .mem_wb_reg   (mem_wb_reg),
    .mem_wb_data  (mem_wb_data),
    .dst_reg      (dst_reg),
    .dst_data     (dst_data),
    .write_reg    (write_reg),
    .write_en     (write_en),
    .RF_bypass_en1(RF_bypass_en1),
    .RF_bypass_en2(RF_bypass_en2),
    .stall        (stall),
    .busy_map     (busy_map)
  );

`ifdef RF_WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic [3:0]  rg;
    logic [15:0] data;
    logic        we;
  } wb_exp_t;

  typedef struct {
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        ea;
    logic        em;
  } vec_t;

  wb_exp_t sb_q[$];
  vec_t    vecs[10];
  int      tests_run = 0;
  int      tests_failed = 0;

  task automatic check_bit(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] actual, input logic [3:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                input logic mv, input logic [3:0] mr, input logic [15:0] md);
    alu_wb_valid = av;
    alu_wb_reg   = ar;
    alu_wb_data  = ad;
    mem_wb_valid = mv;
    mem_wb_reg   = mr;
    mem_wb_data  = md;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic apply_issue(input logic iv, input logic iw, input logic [3:0] rs,
                             input logic [3:0] rt, input logic [3:0] dst);
    issue_valid = iv;
    issue_wr    = iw;
    issue_rs    = rs;
    issue_rt    = rt;
    issue_dst   = dst;
  endtask

  // Called once per cycle at the falling edge: checks handshakes, retires last cycle's expected write, records this cycle's.
  task automatic check_output(input string name, input logic exp_a, input logic exp_m);
    wb_exp_t e;
    check_bit({name, " alu_ready"}, alu_wb_ready, exp_a);
    check_bit({name, " mem_ready"}, mem_wb_ready, exp_m);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_bit({name, " write_en"}, write_en, e.we);
      check_bit({name, " write_reg"}, write_reg, e.we);
      if (e.we) begin
        check_reg({name, " dst_reg"}, dst_reg, e.rg);
        check_word({name, " dst_data"}, dst_data, e.data);
      end
    end else begin
      check_bit({name, " write_en idle"}, write_en, 1'b0);
      check_bit({name, " write_reg idle"}, write_reg, 1'b0);
    end
    if (exp_a) sb_q.push_back('{alu_wb_reg, alu_wb_data, (alu_wb_reg != 4'd0)});
    if (exp_m) sb_q.push_back('{mem_wb_reg, mem_wb_data, (mem_wb_reg != 4'd0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hB001, 1'b0,   1'b1};
    vecs[1] = '{1'b1, 4'd1, 16'hA002, 1'b1, 4'd2, 16'hB002, ~FIXED, FIXED};
    vecs[2] = '{1'b1, 4'd1, 16'hA003, 1'b1, 4'd2, 16'hB003, 1'b0,   1'b1};
    vecs[3] = '{1'b1, 4'd1, 16'hA004, 1'b1, 4'd2, 16'hB004, ~FIXED, FIXED};
    vecs[4] = '{1'b1, 4'd3, 16'hA005, 1'b0, 4'd0, 16'h0000, 1'b1,   1'b0};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'hB006, 1'b0,   1'b1};
    vecs[6] = '{1'b1, 4'd8, 16'hA007, 1'b1, 4'd9, 16'hB007, ~FIXED, FIXED};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,   1'b0};
    vecs[8] = '{1'b1, 4'd0, 16'hA009, 1'b0, 4'd0, 16'h0000, 1'b1,   1'b0};
    vecs[9] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,   1'b0};

    // Held in reset with both sources requesting: nothing may be granted or written.
    apply_stimulus(1'b1, 4'd3, 16'h1111, 1'b1, 4'd4, 16'h2222);
    apply_issue(1'b1, 1'b0, 4'd3, 4'd4, 4'd0);
    @(negedge clk);
    check_output("reset", 1'b0, 1'b0);
    check_reg("reset dst_reg", dst_reg, 4'd0);
    check_word("reset dst_data", dst_data, 16'd0);
    check_word("reset busy_map", busy_map, 16'h0000);
    check_bit("reset stall", stall, 1'b0);
    check_bit("reset bypass1", RF_bypass_en1, 1'b0);
    apply_idle();
    #1 rst = 1'b1;
    tick();

    apply_issue(1'b1, 1'b0, 4'd3, 4'd4, 4'd0);
    @(negedge clk);
    check_output("post_reset", 1'b0, 1'b0);
    check_bit("post_reset stall", stall, 1'b0);
    check_word("post_reset busy_map", busy_map, 16'h0000);
    tick();

    // Read-after-write on r5 resolved by the ALU writeback and its bypass.
    apply_issue(1'b1, 1'b1, 4'd1, 4'd2, 4'd5);
    @(negedge clk);
    check_output("raw_issue", 1'b0, 1'b0);
    check_bit("raw_issue stall", stall, 1'b0);
    tick();
    apply_issue(1'b1, 1'b0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    check_output("raw_wait", 1'b0, 1'b0);
    check_bit("raw_wait stall", stall, 1'b1);
    check_word("raw_wait busy_map", busy_map, 16'h0020);
    tick();
    apply_stimulus(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check_output("raw_alu", 1'b1, 1'b0);
    check_bit("raw_alu stall", stall, 1'b1);
    tick();
    apply_idle();
    @(negedge clk);
    check_output("raw_commit", 1'b0, 1'b0);
    check_bit("raw_commit stall", stall, 1'b0);
    check_bit("raw_commit bypass1", RF_bypass_en1, 1'b1);
    check_bit("raw_commit bypass2", RF_bypass_en2, 1'b0);
    check_word("raw_commit busy_map", busy_map, 16'h0020);
    tick();
    apply_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("raw_after", 1'b0, 1'b0);
    check_word("raw_after busy_map", busy_map, 16'h0000);
    tick();

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i].ea, vecs[i].em);
      tick();
    end
    apply_idle();
    @(negedge clk);
    check_output("vec_drain", 1'b0, 1'b0);
    check_word("vec_drain busy_map", busy_map, 16'h0000);
    tick();

    // Retire of r7 and a new reservation of r7 on the same edge.
    apply_stimulus(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check_output("waw_alu", 1'b1, 1'b0);
    tick();
    apply_idle();
    apply_issue(1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
    @(negedge clk);
    check_output("waw_commit", 1'b0, 1'b0);
    check_bit("waw_commit stall", stall, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd7, 16'h7778, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check_output("waw_stall", 1'b1, 1'b0);
    check_word("waw_stall busy_map", busy_map, 16'h0080);
    check_bit("waw_stall stall", stall, 1'b1);
    tick();
    apply_idle();
    apply_issue(1'b1, 1'b0, 4'd0, 4'd7, 4'd0);
    @(negedge clk);
    check_output("waw_clear", 1'b0, 1'b0);
    check_bit("waw_clear bypass1", RF_bypass_en1, 1'b0);
    check_bit("waw_clear bypass2", RF_bypass_en2, 1'b1);
    check_bit("waw_clear stall", stall, 1'b0);
    tick();
    apply_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("waw_idle", 1'b0, 1'b0);
    check_word("waw_idle busy_map", busy_map, 16'h0000);
    tick();

    // Load writeback to r0 and issues touching r0.
    apply_stimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'h1234);
    apply_issue(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("r0_mem", 1'b0, 1'b1);
    check_bit("r0_mem stall", stall, 1'b0);
    tick();
    apply_idle();
    apply_issue(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("r0_commit", 1'b0, 1'b0);
    check_bit("r0_commit stall", stall, 1'b0);
    check_word("r0_commit busy_map", busy_map, 16'h0000);
    tick();

    // Reserve r4..r7, then flush while r6 is being written back.
    for (int r = 4; r < 8; r++) begin
      apply_issue(1'b1, 1'b1, 4'd0, 4'd0, 4'(r));
      @(negedge clk);
      check_output($sformatf("fill%0d", r), 1'b0, 1'b0);
      check_bit($sformatf("fill%0d stall", r), stall, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd6, 16'h6666);
    apply_issue(1'b1, 1'b1, 4'd0, 4'd0, 4'd9);
    flush = 1'b1;
    @(negedge clk);
    check_output("flush_mem", 1'b0, 1'b1);
    check_word("flush_mem busy_map", busy_map, 16'h00F0);
    check_bit("flush_mem stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    apply_idle();
    apply_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("flush_commit", 1'b0, 1'b0);
    check_word("flush_commit busy_map", busy_map, 16'h0000);
    tick();

    // Reset lands while a write is registered; afterwards arbitration restarts favouring mem.
    apply_stimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd10, 16'hAAAA);
    @(negedge clk);
    check_output("rst_xfer", 1'b0, 1'b1);
    tick();
    #1 rst = 1'b0;
    sb_q.delete();
    apply_stimulus(1'b1, 4'd11, 16'hC001, 1'b1, 4'd12, 16'hC002);
    @(negedge clk);
    check_output("rst_hold", 1'b0, 1'b0);
    check_reg("rst_hold dst_reg", dst_reg, 4'd0);
    check_word("rst_hold dst_data", dst_data, 16'd0);
    check_word("rst_hold busy_map", busy_map, 16'h0000);
    apply_idle();
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    check_output("rst_idle", 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 4'd11, 16'hC001, 1'b1, 4'd12, 16'hC002);
    @(negedge clk);
    check_output("rst_prio", 1'b0, 1'b1);
    tick();
    apply_idle();
    @(negedge clk);
    check_output("rst_commit", 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check_output("rst_final", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
